st_tx_arbiter: RTL and testbench
================================

Name: st_tx_arbiter

Overview:
Merges the three transmit packet streams into the single stream feeding the TSE MAC transmit port.
- Sources: ARP replies, search-device responses, UDP frames from udp2axi.
- Packet-level round-robin arbiter. Once a source is granted, it stays locked until its tlast beat is accepted, so frames are never interleaved.
- Registered output stage gives clean timing toward the MAC.
- Transmit-side counterpart of the receive stream splitter.

Parameters:
DATA_W, 32, stream data width in bits
KEEP_W, 4, byte-enable width (DATA_W/8)

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
arp_tdata_i  in  DATA_W  ARP source data (source index 0)
arp_tvld_i  in  1  ARP valid
arp_tlast_i  in  1  ARP last beat
arp_tkeep_i  in  KEEP_W  ARP byte enables
arp_trdy_o  out  1  ARP ready
sd_tdata_i / sd_tvld_i / sd_tlast_i / sd_tkeep_i / sd_trdy_o  same as arp_*  search-device source (index 1)
ua_tdata_i / ua_tvld_i / ua_tlast_i / ua_tkeep_i / ua_trdy_o  same as arp_*  udp2axi source (index 2)
to_tse_tdata_o  out  DATA_W  merged data to MAC
to_tse_tvld_o  out  1  merged valid
to_tse_tlast_o  out  1  merged last
to_tse_tkeep_o  out  KEEP_W  merged byte enables
to_tse_trdy_i  in  1  MAC ready
grant_o  out  3  one-hot locked source; 0 in IDLE
busy_o  out  1  1 while in LOCK

Behaviour:
- Reset values:
  - All trdy_o = 0, to_tse_tvld_o = 0; to_tse data/last/keep = 0.
  - grant_o = 0, busy_o = 0, state = IDLE.
  - Round-robin pointer last_idx = 2, so ARP has first priority after reset.
- Handshake: a beat transfers when tvld & trdy are both 1 in the same cycle. Sources must hold data stable while tvld=1 and trdy=0.
- States:
  - IDLE:
    - All source trdy = 0.
    - If any tvld_i=1, pick the first requester scanning last_idx+1, last_idx+2, last_idx+3 (mod 3).
    - Register the grant; go to LOCK next cycle.
    - No requests: stay in IDLE.
  - LOCK:
    - Only the granted source sees trdy = out_ready. All others see 0.
    - out_ready = !to_tse_tvld_o | to_tse_trdy_i.
    - On an accepted beat with tlast=1: last_idx <= granted index, then go to IDLE.
    - If the granted source drops tvld mid-packet, stay in LOCK indefinitely (no timeout); output valid goes low once the output register drains.
- Output register:
  - Loads on every accepted source beat; to_tse_tvld_o <= 1.
  - Clears valid when to_tse_trdy_i=1 and no new beat is loaded.
  - Holds data, last and keep while tvld_o=1 and trdy_i=0.
- Latency:
  - A beat accepted from a source in cycle N appears on to_tse in cycle N+1.
  - First beat of a packet: tvld seen in IDLE at cycle N, trdy at N+1, output at N+2.
  - Exactly one idle-arbitration cycle between consecutive packets. Full throughput (1 beat/cycle) within a packet.
- Simultaneous events:
  - tlast accepted and new requests pending: the decision is made in the following IDLE cycle using the updated last_idx.
  - Output drain and load in the same cycle: the load wins (valid stays 1).
- Requests that appear while in LOCK are ignored until IDLE. A new request never preempts a locked packet.
- tkeep and tlast are passed through unchanged; no checking of keep patterns.
- Reset mid-packet:
  - Immediate return to reset values; the output beat in flight is dropped.
  - The truncated frame is lost. Sources are reset by the same reset.

Decomposition:
- Shared package st_pkg: DATA_W/KEEP_W constants, source index constants (SRC_ARP=0, SRC_SD=1, SRC_UA=2, NUM_SRC=3), state enum {IDLE, LOCK}.
- Sub-module st_out_reg: one-deep output pipeline register with the ready equation above.
- Arbiter FSM and mux stay in st_tx_arbiter.

Test Plan:
- ARP alone sends a 4-beat packet (0x11111111..0x44444444, last keep=4'b0011), to_tse_trdy_i=1 -> identical 4 beats on to_tse; first beat 2 cycles after arp_tvld rises; grant_o=3'b001 during the packet.
- All three sources present 3-beat packets simultaneously after reset -> order ARP, SD, UA; no interleaving; exactly 1 idle cycle between packets; grant_o sequence 001, 010, 100.
- to_tse_trdy_i toggled 1,0,0,1,... during a 6-beat SD packet -> no beat lost or duplicated; to_tse data stable while trdy=0; sd_trdy_o=0 whenever the output register is full and the MAC stalls.
- UA drops tvld for 5 cycles mid-packet while ARP requests -> ARP not granted until UA tlast is accepted; busy_o=1 throughout.
- Back-to-back single-beat packets (tlast on every beat) from SD only -> one beat every 2 cycles; last_idx rotation still grants ARP first if it requests.
- reset asserted for 1 cycle during beat 3 of a 5-beat ARP packet -> next cycle: to_tse_tvld_o=0, grant_o=0, all trdy=0; the next packet after reset is granted to ARP first.

Source files
------------

// File: rtl/st_pkg.sv
// Shared constants, source indices and arbiter state encoding for the
// transmit-side stream merger.
package st_pkg;

  localparam int DATA_W  = 32;
  localparam int KEEP_W  = DATA_W / 8;
  localparam int NUM_SRC = 3;

  localparam logic [1:0] SRC_ARP = 2'd0;
  localparam logic [1:0] SRC_SD  = 2'd1;
  localparam logic [1:0] SRC_UA  = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // First requester found scanning last_idx+1, +2, +3 (mod NUM_SRC).
  function automatic logic [1:0] rr_pick(input logic [1:0]         last_idx,
                                         input logic [NUM_SRC-1:0] req);
    logic [1:0] pick;
    logic [1:0] cand;
    pick = last_idx;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = 2'((int'(last_idx) + k) % NUM_SRC);
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

endpackage

// File: rtl/st_out_reg.sv
// One-deep registered output stage toward the MAC; accepts a new beat whenever
// it is empty or its current beat is leaving in the same cycle.
module st_out_reg #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              out_trdy,
  output logic              out_ready,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [KEEP_W-1:0] out_keep
);

  assign out_ready = !out_vld || out_trdy;

  // A load in the same cycle as a drain keeps valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_keep <= '0;
    end else if (load) begin
      out_vld  <= 1'b1;
      out_data <= in_data;
      out_last <= in_last;
      out_keep <= in_keep;
    end else if (out_trdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/st_tx_arbiter.sv
// Packet-level round-robin merge of the ARP, search-device and udp2axi transmit
// streams into the single MAC transmit stream; a granted source owns the output until tlast.
module st_tx_arbiter #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] arp_tdata_i,
  input  logic              arp_tvld_i,
  input  logic              arp_tlast_i,
  input  logic [KEEP_W-1:0] arp_tkeep_i,
  output logic              arp_trdy_o,
  input  logic [DATA_W-1:0] sd_tdata_i,
  input  logic              sd_tvld_i,
  input  logic              sd_tlast_i,
  input  logic [KEEP_W-1:0] sd_tkeep_i,
  output logic              sd_trdy_o,
  input  logic [DATA_W-1:0] ua_tdata_i,
  input  logic              ua_tvld_i,
  input  logic              ua_tlast_i,
  input  logic [KEEP_W-1:0] ua_tkeep_i,
  output logic              ua_trdy_o,
  output logic [DATA_W-1:0] to_tse_tdata_o,
  output logic              to_tse_tvld_o,
  output logic              to_tse_tlast_o,
  output logic [KEEP_W-1:0] to_tse_tkeep_o,
  input  logic              to_tse_trdy_i,
  output logic [2:0]        grant_o,
  output logic              busy_o
);

  import st_pkg::*;

  // Handshake: every stream moves a beat in a cycle where tvld and trdy are both
  // high; a source holds data/last/keep stable while tvld=1 and trdy=0.

  logic [DATA_W-1:0]  src_data [NUM_SRC];
  logic [KEEP_W-1:0]  src_keep [NUM_SRC];
  logic [NUM_SRC-1:0] src_vld;
  logic [NUM_SRC-1:0] src_last;
  logic [NUM_SRC-1:0] src_rdy;

  assign src_data[SRC_ARP] = arp_tdata_i;
  assign src_data[SRC_SD]  = sd_tdata_i;
  assign src_data[SRC_UA]  = ua_tdata_i;
  assign src_keep[SRC_ARP] = arp_tkeep_i;
  assign src_keep[SRC_SD]  = sd_tkeep_i;
  assign src_keep[SRC_UA]  = ua_tkeep_i;
  assign src_vld  = {ua_tvld_i, sd_tvld_i, arp_tvld_i};
  assign src_last = {ua_tlast_i, sd_tlast_i, arp_tlast_i};

  assign arp_trdy_o = src_rdy[SRC_ARP];
  assign sd_trdy_o  = src_rdy[SRC_SD];
  assign ua_trdy_o  = src_rdy[SRC_UA];

  state_t             state;
  state_t             state_nx;
  logic [1:0]         grant_idx;
  logic [1:0]         grant_idx_nx;
  logic [1:0]         last_idx;
  logic [1:0]         last_idx_nx;
  logic               out_ready;
  logic               beat_acc;
  logic [NUM_SRC-1:0] grant_oh;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant_idx <= SRC_ARP;
      last_idx  <= SRC_UA;
    end else begin
      state     <= state_nx;
      grant_idx <= grant_idx_nx;
      last_idx  <= last_idx_nx;
    end
  end

  // Requests raised while locked are simply not looked at until IDLE.
  always_comb begin
    state_nx     = state;
    grant_idx_nx = grant_idx;
    last_idx_nx  = last_idx;
    src_rdy      = '0;
    beat_acc     = 1'b0;
    case (state)
      IDLE: begin
        if (|src_vld) begin
          grant_idx_nx = rr_pick(last_idx, src_vld);
          state_nx     = LOCK;
        end
      end
      LOCK: begin
        src_rdy[grant_idx] = out_ready;
        beat_acc           = src_vld[grant_idx] && out_ready;
        if (beat_acc && src_last[grant_idx]) begin
          last_idx_nx = grant_idx;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    grant_oh = '0;
    if (state == LOCK) grant_oh[grant_idx] = 1'b1;
  end

  assign grant_o = grant_oh;
  assign busy_o  = (state == LOCK);

  st_out_reg #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (beat_acc),
    .in_data   (src_data[grant_idx]),
    .in_last   (src_last[grant_idx]),
    .in_keep   (src_keep[grant_idx]),
    .out_trdy  (to_tse_trdy_i),
    .out_ready (out_ready),
    .out_vld   (to_tse_tvld_o),
    .out_data  (to_tse_tdata_o),
    .out_last  (to_tse_tlast_o),
    .out_keep  (to_tse_tkeep_o)
  );

endmodule

// File: tb/tb_st_tx_arbiter.sv
// Directed scoreboard bench for st_tx_arbiter: expected beats are queued in
// arbitration order when stimulus starts and popped on each MAC-side transfer.
module tb_st_tx_arbiter;

  import st_pkg::*;

  localparam int EW = DATA_W + KEEP_W + 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] s_data [3];
  logic [KEEP_W-1:0] s_keep [3];
  logic              s_vld  [3];
  logic              s_last [3];
  logic              s_rdy  [3];
  logic              mac_rdy;
  logic [DATA_W-1:0] o_data;
  logic              o_vld;
  logic              o_last;
  logic [KEEP_W-1:0] o_keep;
  logic [2:0]        grant;
  logic              busy;

  st_tx_arbiter #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .arp_tdata_i    (s_data[0]),
    .arp_tvld_i     (s_vld[0]),
    .arp_tlast_i    (s_last[0]),
    .arp_tkeep_i    (s_keep[0]),
    .arp_trdy_o     (s_rdy[0]),
    .sd_tdata_i     (s_data[1]),
    .sd_tvld_i      (s_vld[1]),
    .sd_tlast_i     (s_last[1]),
    .sd_tkeep_i     (s_keep[1]),
    .sd_trdy_o      (s_rdy[1]),
    .ua_tdata_i     (s_data[2]),
    .ua_tvld_i      (s_vld[2]),
    .ua_tlast_i     (s_last[2]),
    .ua_tkeep_i     (s_keep[2]),
    .ua_trdy_o      (s_rdy[2]),
    .to_tse_tdata_o (o_data),
    .to_tse_tvld_o  (o_vld),
    .to_tse_tlast_o (o_last),
    .to_tse_tkeep_o (o_keep),
    .to_tse_trdy_i  (mac_rdy),
    .grant_o        (grant),
    .busy_o         (busy)
  );

  int            checks    = 0;
  int            failures  = 0;
  int            cyc       = 0;
  int            beats_out = 0;
  logic [EW-1:0] exp_q[$];
  int            out_cyc[$];
  logic [2:0]    grant_seq[$];
  logic [2:0]    grant_prev = 3'b000;
  logic          stalled_prev = 1'b0;
  logic [EW-1:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (!reset && o_vld && mac_rdy) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_beat observed=%0h expected=none", {o_last, o_keep, o_data});
      end
      if (exp_q.size() != 0) chk("out_beat", {o_last, o_keep, o_data}, exp_q.pop_front());
      out_cyc.push_back(cyc);
      beats_out++;
    end
    if (!reset && o_vld && !mac_rdy)
      chk("stall_trdy", {s_rdy[2], s_rdy[1], s_rdy[0]}, 3'b000);
    if (!reset && stalled_prev) chk("hold_beat", {o_last, o_keep, o_data}, held);
    stalled_prev = !reset && o_vld && !mac_rdy;
    held = {o_last, o_keep, o_data};
    if (!reset && grant != 3'b000 && grant != grant_prev) grant_seq.push_back(grant);
    grant_prev = grant;
  end

  // driver tasks
  task automatic push_pkt(input int n, input logic [31:0] base, input logic [3:0] lkeep);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), ((i == n - 1) ? lkeep : 4'hf), base * 32'(i + 1)});
  endtask

  task automatic send(input int src, input int n, input logic [31:0] base,
                      input logic [3:0] lkeep, input int gap_at, input int gap_len);
    int wait_c;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at && gap_len > 0) begin
        s_vld[src] = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      s_data[src] = base * 32'(i + 1);
      s_keep[src] = (i == n - 1) ? lkeep : 4'hf;
      s_last[src] = (i == n - 1);
      s_vld[src]  = 1'b1;
      wait_c = 0;
      while (1'b1) begin
        @(negedge clk);
        if (reset) begin
          s_vld[src]  = 1'b0;
          s_last[src] = 1'b0;
          return;
        end
        if (s_rdy[src]) break;
        wait_c++;
        if (wait_c > 200) begin
          checks++;
          failures++;
          $error("FAIL src_timeout src=%0d observed=stalled expected=accepted", src);
          s_vld[src] = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    s_vld[src]  = 1'b0;
    s_last[src] = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int b0;
    reset   = 1'b1;
    mac_rdy = 1'b1;
    for (int s = 0; s < 3; s++) begin
      s_data[s] = '0; s_keep[s] = '0; s_vld[s] = 1'b0; s_last[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvld", o_vld, 0);
    chk("rst_out", {o_last, o_keep, o_data}, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trdy", {s_rdy[2], s_rdy[1], s_rdy[0]}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // all three sources at once from reset: ARP, SD, UA
    out_cyc.delete(); grant_seq.delete();
    push_pkt(3, 32'h0000_0A01, 4'h1);
    push_pkt(3, 32'h0000_0B01, 4'h3);
    push_pkt(3, 32'h0000_0C01, 4'h7);
    fork
      send(0, 3, 32'h0000_0A01, 4'h1, -1, 0);
      send(1, 3, 32'h0000_0B01, 4'h3, -1, 0);
      send(2, 3, 32'h0000_0C01, 4'h7, -1, 0);
    join
    wait_drain();
    chk("t2_beats", out_cyc.size(), 9);
    for (int i = 1; i < out_cyc.size() && i < 9; i++)
      chk("t2_gap", out_cyc[i] - out_cyc[i-1], (i % 3 == 0) ? 2 : 1);
    chk("t2_grants", grant_seq.size(), 3);
    for (int i = 0; i < grant_seq.size() && i < 3; i++)
      chk("t2_grant_seq", grant_seq[i], 3'b001 << i);

    // ARP alone, 4 beats, partial keep on last
    out_cyc.delete();
    start = cyc;
    push_pkt(4, 32'h1111_1111, 4'b0011);
    fork
      send(0, 4, 32'h1111_1111, 4'b0011, -1, 0);
      begin
        repeat (3) @(negedge clk);
        chk("t1_grant", grant, 3'b001);
        chk("t1_busy", busy, 1);
      end
    join
    wait_drain();
    chk("t1_beats", out_cyc.size(), 4);
    if (out_cyc.size() != 0) chk("t1_latency", out_cyc[0] - start, 2);
    for (int i = 1; i < out_cyc.size(); i++) chk("t1_gap", out_cyc[i] - out_cyc[i-1], 1);

    // SD 6 beats with MAC ready 1,0,0,1,0,0...
    push_pkt(6, 32'h0000_5D01, 4'hf);
    fork
      send(1, 6, 32'h0000_5D01, 4'hf, -1, 0);
      for (int k = 0; k < 30; k++) begin
        mac_rdy = (k % 3 == 0);
        @(posedge clk);
        #1;
      end
    join
    mac_rdy = 1'b1;
    wait_drain();

    // UA pauses mid-packet while ARP requests
    push_pkt(4, 32'h0000_AA01, 4'h3);
    push_pkt(2, 32'h0000_1101, 4'hf);
    fork
      send(2, 4, 32'h0000_AA01, 4'h3, 2, 5);
      begin
        repeat (3) @(posedge clk);
        #1;
        send(0, 2, 32'h0000_1101, 4'hf, -1, 0);
      end
      begin
        repeat (5) @(negedge clk);
        chk("t4_busy", busy, 1);
        chk("t4_grant", grant, 3'b100);
        chk("t4_arp_trdy", s_rdy[0], 0);
        @(negedge clk);
        chk("t4_drained", o_vld, 0);
        @(negedge clk);
        chk("t4_busy_late", busy, 1);
        chk("t4_grant_late", grant, 3'b100);
      end
    join
    wait_drain();

    // SD single-beat packets back to back, then ARP+SD, then ARP alone
    out_cyc.delete();
    for (int k = 0; k < 3; k++) begin
      push_pkt(1, 32'h0000_5100 + 32'(k), 4'h1);
      send(1, 1, 32'h0000_5100 + 32'(k), 4'h1, -1, 0);
    end
    wait_drain();
    chk("t5_beats", out_cyc.size(), 3);
    for (int i = 1; i < out_cyc.size(); i++) chk("t5_gap", out_cyc[i] - out_cyc[i-1], 2);
    grant_seq.delete();
    push_pkt(1, 32'h0000_00A5, 4'h1);
    push_pkt(1, 32'h0000_00B5, 4'h3);
    fork
      send(0, 1, 32'h0000_00A5, 4'h1, -1, 0);
      send(1, 1, 32'h0000_00B5, 4'h3, -1, 0);
    join
    wait_drain();
    chk("t5_grants", grant_seq.size(), 2);
    if (grant_seq.size() > 1) begin
      chk("t5_first", grant_seq[0], 3'b001);
      chk("t5_second", grant_seq[1], 3'b010);
    end
    push_pkt(1, 32'h0000_00C5, 4'hf);
    send(0, 1, 32'h0000_00C5, 4'hf, -1, 0);
    wait_drain();

    // reset during beat 3 of a 5-beat ARP packet
    push_pkt(5, 32'h0000_6601, 4'hf);
    b0 = beats_out;
    fork
      send(0, 5, 32'h0000_6601, 4'hf, -1, 0);
      begin
        int t;
        t = 0;
        while (beats_out < b0 + 2 && t < 100) begin
          @(posedge clk);
          t++;
        end
        chk("t6_pre_beats", beats_out - b0, 2);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t6_tvld", o_vld, 0);
        chk("t6_grant", grant, 0);
        chk("t6_busy", busy, 0);
        chk("t6_trdy", {s_rdy[2], s_rdy[1], s_rdy[0]}, 0);
        exp_q.delete();
      end
    join
    @(posedge clk);
    #1;
    grant_seq.delete();
    push_pkt(2, 32'h0000_7A01, 4'h1);
    push_pkt(2, 32'h0000_7B01, 4'h3);
    fork
      send(0, 2, 32'h0000_7A01, 4'h1, -1, 0);
      send(1, 2, 32'h0000_7B01, 4'h3, -1, 0);
    join
    wait_drain();
    chk("t6_grants", grant_seq.size(), 2);
    if (grant_seq.size() != 0) chk("t6_first_after_reset", grant_seq[0], 3'b001);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
